// File: rtl/hazard_scoreboard.sv
// Register scoreboard for the in-order pipeline.
// Tracks pending writes per register, raises RAW/WAW stalls and runs the drain handshake.
module hazard_scoreboard #(
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [3:0]      id_src_1,
    input  logic [3:0]      id_src_2,
    input  logic            id_two_src,
    input  logic [3:0]      id_dest,
    input  logic            id_wb_en,
    input  logic            wb_valid,
    input  logic [3:0]      wb_dest,
    input  logic            branch_taken,
    input  logic            drain_req,
    output logic            hazard,
    output logic            flush,
    output logic            drain_ack,
    output logic [NREG-1:0] busy_mask,
    output logic [15:0]     stall_cycles,
    output logic            wb_err
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cnt     [NREG];
    logic [1:0]      cnt_nxt [NREG];
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic            src1_busy;
    logic            src2_busy;
    logic            dest_full;
    logic            wb_hit_busy;
    logic            all_idle;
    logic            issue;

    always_comb begin
        src1_busy   = 1'b0;
        src2_busy   = 1'b0;
        dest_full   = 1'b0;
        wb_hit_busy = 1'b0;
        busy_mask   = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = cnt[r] != 2'd0;
            if (4'(r) == id_src_1) src1_busy   = cnt[r] != 2'd0;
            if (4'(r) == id_src_2) src2_busy   = cnt[r] != 2'd0;
            if (4'(r) == id_dest)  dest_full   = cnt[r] == 2'd3;
            if (4'(r) == wb_dest)  wb_hit_busy = cnt[r] != 2'd0;
        end
    end

    assign all_idle  = ~|busy_mask;
    assign flush     = branch_taken;
    assign drain_ack = state == HALTED;

    // No writeback bypass: the check only sees registered counters.
    assign hazard = id_valid & (src1_busy
                              | (id_two_src & src2_busy)
                              | (id_wb_en & dest_full)
                              | (state != RUN));

    assign issue = id_valid & id_wb_en & ~hazard & ~flush;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_vec[r] = issue & (4'(r) == id_dest);
            dec_vec[r] = wb_valid & (4'(r) == wb_dest) & (cnt[r] != 2'd0);
            cnt_nxt[r] = cnt[r];
            if (inc_vec[r] & ~dec_vec[r])
                cnt_nxt[r] = cnt[r] + 2'd1;
            else if (dec_vec[r] & ~inc_vec[r])
                cnt_nxt[r] = cnt[r] - 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (drain_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)    state_nxt = RUN;
                else if (all_idle) state_nxt = HALTED;
            end
            HALTED: begin
                if (!drain_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            stall_cycles <= '0;
            wb_err       <= 1'b0;
            for (int r = 0; r < NREG; r++) cnt[r] <= 2'd0;
        end else begin
            state  <= state_nxt;
            wb_err <= wb_err | (wb_valid & ~wb_hit_busy);
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (hazard && !flush && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed table, corner sequences,
// and random traffic against a pending-count reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_two_src, id_wb_en, wb_valid;
    logic        branch_taken, drain_req;
    logic [3:0]  id_src_1, id_src_2, id_dest, wb_dest;
    logic        hazard, flush, drain_ack, wb_err;
    logic [15:0] busy_mask, stall_cycles;

    int checks = 0;
    int passed = 0;

    hazard_scoreboard #(.NREG(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src_1(id_src_1), .id_src_2(id_src_2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .branch_taken(branch_taken), .drain_req(drain_req),
        .hazard(hazard), .flush(flush), .drain_ack(drain_ack),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes per register, mode 0=run 1=drain 2=halted
    int pend [16];
    int mode;
    int stalls;
    bit err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit m_hazard();
        if (!id_valid) return 1'b0;
        return pend[id_src_1] != 0 || (id_two_src && pend[id_src_2] != 0)
            || (id_wb_en && pend[id_dest] == 3) || mode != 0;
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b = '0;
        for (int i = 0; i < 16; i++) b[i] = pend[i] != 0;
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) pend[i] = 0;
        mode = 0; stalls = 0; err = 0;
    endtask

    task automatic m_edge();
        bit hz, iss, all0;
        hz   = m_hazard();
        iss  = id_valid && id_wb_en && !hz && !branch_taken;
        all0 = m_busy() == 16'h0;
        if (hz && !branch_taken && stalls < 65535) stalls++;
        if (wb_valid) begin
            if (pend[wb_dest] == 0) err = 1;
            else pend[wb_dest]--;
        end
        if (iss) pend[id_dest]++;
        case (mode)
            0: if (drain_req) mode = 1;
            1: if (!drain_req) mode = 0; else if (all0) mode = 2;
            default: if (!drain_req) mode = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hazard"}, 32'(hazard), 32'(m_hazard()));
        chk({tag, ".flush"}, 32'(flush), 32'(branch_taken));
        chk({tag, ".busy"}, 32'(busy_mask), 32'(m_busy()));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(stalls));
        chk({tag, ".wb_err"}, 32'(wb_err), 32'(err));
        chk({tag, ".drain_ack"}, 32'(drain_ack), 32'(mode == 2));
    endtask

    task automatic idle();
        id_valid = 0; id_src_1 = 0; id_src_2 = 0; id_two_src = 0;
        id_dest = 0; id_wb_en = 0; wb_valid = 0; wb_dest = 0;
        branch_taken = 0; drain_req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        m_reset();
        step();
        step();
        rst = 1;
    endtask

    task automatic drive(input int v, s1, s2, two, d, we, wbv, wbd, br, dr);
        id_valid = 1'(v); id_src_1 = 4'(s1); id_src_2 = 4'(s2);
        id_two_src = 1'(two); id_dest = 4'(d); id_wb_en = 1'(we);
        wb_valid = 1'(wbv); wb_dest = 4'(wbd);
        branch_taken = 1'(br); drain_req = 1'(dr);
    endtask

    typedef struct {
        int v, s1, s2, two, d, we, wbv, wbd, br, dr;
        int hz, fl, busy, stall;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input int v, s1, s2, two, d, we, wbv, wbd, br, dr,
                                input int hz, fl, busy, stall);
        vec_t t;
        t.v = v; t.s1 = s1; t.s2 = s2; t.two = two; t.d = d; t.we = we;
        t.wbv = wbv; t.wbd = wbd; t.br = br; t.dr = dr;
        t.hz = hz; t.fl = fl; t.busy = busy; t.stall = stall;
        return t;
    endfunction

    initial begin
        int pick [$];
        tbl[0]  = mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 'h0000, 0);
        tbl[1]  = mk(1, 3, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 'h0008, 0);
        tbl[2]  = mk(1, 3, 0, 0, 4, 1, 1, 3, 0, 0, 1, 0, 'h0008, 1);
        tbl[3]  = mk(1, 3, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 'h0000, 2);
        tbl[4]  = mk(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'h0010, 2);
        tbl[5]  = mk(1, 0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 'h0030, 2);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 'h0030, 2);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0020, 2);
        tbl[8]  = mk(1, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 1, 'h0020, 2);
        tbl[9]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0020, 2);
        tbl[10] = mk(1, 6, 5, 1, 7, 1, 0, 0, 0, 0, 1, 0, 'h0020, 2);
        tbl[11] = mk(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 'h0020, 3);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 'h0020, 3);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h0000, 3);

        rst = 0;
        idle();
        m_reset();
        #2;
        chk("reset.busy", 32'(busy_mask), 32'h0);
        chk("reset.drain_ack", 32'(drain_ack), 32'h0);
        chk("reset.stall", 32'(stall_cycles), 32'h0);
        chk("reset.wb_err", 32'(wb_err), 32'h0);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d,
                  tbl[i].we, tbl[i].wbv, tbl[i].wbd, tbl[i].br, tbl[i].dr);
            @(negedge clk);
            chk($sformatf("tbl%0d.hazard", i), 32'(hazard), 32'(tbl[i].hz));
            chk($sformatf("tbl%0d.flush", i), 32'(flush), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d.busy", i), 32'(busy_mask), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.stall", i), 32'(stall_cycles), 32'(tbl[i].stall));
            step();
        end
        chk("tbl.wb_err", 32'(wb_err), 32'h0);

        // Saturation of R7 pending count
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("sat.hazard", 32'(hazard), 32'h1);
            chk("sat.busy7", 32'(busy_mask[7]), 32'h1);
            chk("sat.stall", 32'(stall_cycles), 32'(k));
            step();
        end

        // Drain handshake with R1 and R4 pending
        do_reset();
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("drain.hazard", 32'(hazard), 32'h1);
        chk("drain.busy", 32'(busy_mask), 32'h0012);
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1); step();
        drive(1, 0, 0, 0, 0, 0, 1, 4, 0, 1); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("drain.ack_early", 32'(drain_ack), 32'h0);
        chk("drain.busy_clear", 32'(busy_mask), 32'h0);
        step();
        @(negedge clk);
        chk("drain.ack", 32'(drain_ack), 32'h1);
        chk("halted.hazard", 32'(hazard), 32'h1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        @(negedge clk);
        chk("run.ack", 32'(drain_ack), 32'h0);
        chk("run.hazard", 32'(hazard), 32'h0);

        // Sticky wb_err, then asynchronous reset
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0); step();
        idle();
        @(negedge clk);
        chk("err.set", 32'(wb_err), 32'h1);
        step(); step();
        chk("err.sticky", 32'(wb_err), 32'h1);
        drive(1, 0, 0, 0, 6, 1, 0, 0, 0, 1); step();
        drive(1, 6, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("err.busy6", 32'(busy_mask), 32'h0040);
        #2;
        rst = 0;
        #1;
        chk("async.wb_err", 32'(wb_err), 32'h0);
        chk("async.busy", 32'(busy_mask), 32'h0);
        chk("async.hazard", 32'(hazard), 32'h0);
        chk("async.drain_ack", 32'(drain_ack), 32'h0);
        m_reset();
        #1;
        rst = 1;
        idle();
        step();

        // Random traffic against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom % 4 != 0, $urandom % 8, $urandom % 8, $urandom % 2,
                  $urandom % 8, $urandom % 4 != 0, 0, 0,
                  $urandom % 10 == 0, drain_req);
            if ($urandom % 40 == 0) drain_req = ~drain_req;
            pick.delete();
            for (int i = 0; i < 16; i++) if (pend[i] != 0) pick.push_back(i);
            if ($urandom % 32 == 0) begin
                wb_valid = 1; wb_dest = 4'($urandom % 16);
            end else if (pick.size() != 0 && $urandom % 3 != 0) begin
                wb_valid = 1; wb_dest = 4'(pick[$urandom % pick.size()]);
            end
            if ($urandom % 500 == 0) begin
                rst = 0;
                #1;
                m_reset();
                rst = 1;
            end
            @(negedge clk);
            check_all($sformatf("rnd%0d", n));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one parameter: NREG, default 16, number of tracked architectural registers, indexed by 4-bit register numbers.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a decoded instruction.
- id_src_1  in  4  Rn number of the ID instruction.
- id_src_2  in  4  second source: Rm, or Rd for stores.
- id_two_src  in  1  id_src_2 is a real operand.
- id_dest  in  4  destination register.
- id_wb_en  in  1  ID instruction writes id_dest.
- wb_valid  in  1  a register write completes this cycle.
- wb_dest  in  4  register written.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- drain_req  in  1  request to empty the pipeline (level).
- hazard  out  1  stall IF/ID this cycle.
- flush  out  1  squash the ID instruction this cycle.
- drain_ack  out  1  pipeline empty under drain.
- busy_mask  out  NREG  bit r = pending count of r nonzero.
- stall_cycles  out  16  saturating count of stalled cycles.
- wb_err  out  1  sticky: writeback to a register with no pending write.

Function
REQ-003 The block SHALL keep a 2-bit pending-write counter per register (range 0..3).
REQ-004 Issue SHALL occur when id_valid=1, id_wb_en=1, hazard=0 and flush=0; issue increments the counter of id_dest at the next edge.
REQ-005 When wb_valid=1 and the counter of wb_dest is nonzero, that counter SHALL decrement at the next edge.
REQ-006 Issue and writeback to the same register in the same cycle SHALL leave its counter unchanged.
REQ-007 When wb_valid=1 and the counter of wb_dest is 0, the block SHALL leave the counter at 0 and set wb_err at the next edge; wb_err holds until reset.
REQ-008 hazard SHALL be combinational and equal to id_valid AND (any of the following):
- counter(id_src_1) != 0;
- id_two_src AND counter(id_src_2) != 0;
- id_wb_en AND counter(id_dest) == 3;
- FSM state is not RUN.
REQ-009 The hazard check SHALL use the registered counters; a same-cycle writeback does not clear the hazard (no bypass).
REQ-010 flush SHALL equal branch_taken combinationally; while flush=1, no issue occurs regardless of hazard.
REQ-011 busy_mask SHALL be driven directly from the registered counters.
REQ-012 stall_cycles SHALL increment on every edge where hazard=1 and flush=0, and saturate at 16'hFFFF.
REQ-013 The FSM SHALL have three states:
- RUN: go to DRAIN when drain_req=1.
- DRAIN: go to HALTED when all counters are 0; return to RUN if drain_req drops first.
- HALTED: return to RUN when drain_req=0.
REQ-014 drain_ack SHALL be 1 only in HALTED.
REQ-015 Writebacks SHALL continue to be processed in every state.
REQ-016 branch_taken SHALL NOT alter the counters of instructions already issued; those instructions still write back.

Reset
REQ-017 While rst=0, the block SHALL asynchronously force:
- all counters to 0;
- FSM to RUN;
- stall_cycles and wb_err to 0.
Consequently hazard=0 whenever id_valid=0, busy_mask=0 and drain_ack=0.
REQ-018 A reset asserted mid-drain or mid-stall SHALL discard all pending state; no writeback is expected afterwards.

Verification
REQ-019 RAW stall: issue dest=R3; next cycle ID src_1=R3 -> hazard=1 and busy_mask[3]=1; after wb_valid with wb_dest=3 -> hazard=0 the following cycle.
REQ-020 Same-cycle issue and writeback to R5, with counter(R5)=1 beforehand -> counter(R5) stays 1 and busy_mask[5]=1.
REQ-021 Saturation: three issues to R7 with no writeback; a fourth ID instruction with dest=R7 -> hazard=1 and stall_cycles increments each cycle.
REQ-022 Branch: branch_taken=1 with id_valid=1, dest=R2 -> flush=1, counter(R2) unchanged, stall_cycles unchanged.
REQ-023 Drain: with R1 and R4 pending, raise drain_req -> hazard=1; after both writebacks -> drain_ack=1 next cycle; drop drain_req -> RUN with drain_ack=0.
REQ-024 Error and reset: wb_valid with wb_dest=9 and counter(R9)=0 -> wb_err=1 sticky; pulse rst=0 asynchronously -> wb_err=0, busy_mask=0 immediately.
